// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its operation sequencer.
// Holds:
//   - the data and opcode widths;
//   - the 4-bit opcode constants (0 means no-op: the ALU holds C_bus);
//   - the sequencer FSM state type;
//   - a helper that classifies opcodes the ALU implements.
package alu_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned OpWidth   = 4;

  typedef logic [OpWidth-1:0] alu_op_t;

  localparam alu_op_t OpNop   = 4'd0;
  localparam alu_op_t OpAdd   = 4'd1;
  localparam alu_op_t OpSub   = 4'd2;
  localparam alu_op_t OpMul   = 4'd3;
  localparam alu_op_t OpMod   = 4'd4;
  localparam alu_op_t OpPassA = 4'd5;
  localparam alu_op_t OpPassB = 4'd6;
  localparam alu_op_t OpIncA  = 4'd7;
  localparam alu_op_t OpDecA  = 4'd8;
  localparam alu_op_t OpClr   = 4'd9;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } seq_state_e;

  // Opcodes 1..9 are implemented by the ALU; 0 and 10..15 are not.
  function automatic logic op_is_legal(alu_op_t op);
    return (op >= OpAdd) && (op <= OpClr);
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time over a request/response handshake.
//
// A request (opcode + two operands) is accepted only in the idle state. Legal
// operations are issued to the ALU with a single-cycle enable, the ALU result is
// captured ALU_LATENCY rising edges after the edge that samples the enable, and
// the response is held until the consumer takes it. Illegal opcodes and MOD by
// zero skip the ALU and answer immediately with an error response.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready/req_op/req_a/req_b
//                                    request channel
//   rsp_valid/rsp_ready/rsp_data/rsp_zero/rsp_err
//                                    response channel
//   alu_a_bus/alu_b_bus/alu_control/alu_enable
//                                    operands and command to the ALU
//   alu_c_bus                        ALU result bus
//   ops_done                         wrapping count of completed responses
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [OpWidth-1:0]   req_op,
  input  logic [DataWidth-1:0] req_a,
  input  logic [DataWidth-1:0] req_b,

  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DataWidth-1:0] rsp_data,
  output logic                 rsp_zero,
  output logic                 rsp_err,

  output logic [DataWidth-1:0] alu_a_bus,
  output logic [DataWidth-1:0] alu_b_bus,
  output logic [OpWidth-1:0]   alu_control,
  output logic                 alu_enable,
  input  logic [DataWidth-1:0] alu_c_bus,

  output logic [15:0]          ops_done
);

  localparam logic [3:0] LatCount = 4'(ALU_LATENCY);

  seq_state_e           state_q, state_d;
  alu_op_t              op_q, op_d;
  logic [DataWidth-1:0] a_q, a_d;
  logic [DataWidth-1:0] b_q, b_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [DataWidth-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_zero_q, rsp_zero_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [15:0]          ops_done_q, ops_done_d;

  logic req_is_err;

  // Division by zero is rejected here so the ALU never sees it.
  assign req_is_err = !op_is_legal(alu_op_t'(req_op)) ||
                      ((alu_op_t'(req_op) == OpMod) && (req_b == '0));

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d  = rsp_err_q;
    ops_done_d = ops_done_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d = alu_op_t'(req_op);
          a_d  = req_a;
          b_d  = req_b;
          if (req_is_err) begin
            state_d    = StResp;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            rsp_zero_d = 1'b0;
          end else begin
            state_d   = StIssue;
            rsp_err_d = 1'b0;
          end
        end
      end

      StIssue: begin
        // The edge leaving this state is the one the ALU samples the enable on.
        cnt_d   = LatCount;
        state_d = StWait;
      end

      StWait: begin
        if (cnt_q == 4'd1) begin
          rsp_data_d = alu_c_bus;
          rsp_zero_d = (alu_c_bus == '0);
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StResp: begin
        if (rsp_ready) begin
          state_d    = StIdle;
          ops_done_d = ops_done_q + 16'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= OpNop;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q  <= rsp_err_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign rsp_data    = rsp_data_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_err     = rsp_err_q;
  assign alu_enable  = (state_q == StIssue);
  // Outside ISSUE/WAIT the ALU gets a no-op so it keeps holding its result.
  assign alu_control = ((state_q == StIssue) || (state_q == StWait)) ? op_q : OpNop;
  assign alu_a_bus   = a_q;
  assign alu_b_bus   = b_q;
  assign ops_done    = ops_done_q;

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter: ALU_LATENCY, 2, number of rising clk edges from the edge that samples alu_enable to the edge that captures alu_c_bus (legal 2..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_valid  input  1  request offered.
REQ-005 SHALL have port: req_ready  output  1  sequencer accepts request.
REQ-006 SHALL have port: req_op  input  4  ALU opcode.
REQ-007 SHALL have ports: req_a, req_b  input  32 each  operands.
REQ-008 SHALL have ports: rsp_valid output 1; rsp_ready input 1; rsp_data output 32; rsp_zero output 1; rsp_err output 1.
REQ-009 SHALL have ports: alu_a_bus, alu_b_bus  output  32; alu_control  output  4; alu_enable  output  1.
REQ-010 SHALL have port: alu_c_bus  input  32  ALU result bus.
REQ-011 SHALL have port: ops_done  output  16  count of completed responses.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-013 SHALL, in IDLE on req_valid&&req_ready, latch req_op/req_a/req_b.
REQ-014 SHALL go from IDLE to ISSUE for legal opcodes: 1 ADD, 2 SUB, 3 MUL, 4 MOD, 5 PASSA, 6 PASSB, 7 INCA, 8 DECA, 9 CLR.
REQ-015 SHALL go from IDLE directly to RESP with rsp_err=1, rsp_data=0, rsp_zero=0, and no alu_enable pulse, for opcode 0 or 10-15, or for MOD with req_b==0.
REQ-016 SHALL assert alu_enable for exactly one cycle (ISSUE), then enter WAIT with a down-counter loaded to ALU_LATENCY.
REQ-017 SHALL drive alu_a_bus, alu_b_bus, and alu_control from the latched values, unchanged from ISSUE through the capture edge.
REQ-018 SHALL drive alu_control=0 (no-op, ALU holds C_bus) in IDLE and RESP.
REQ-019 SHALL capture alu_c_bus into rsp_data on the ALU_LATENCY-th rising edge after the enable-sampling edge, then enter RESP.
REQ-020 SHALL set rsp_zero=(captured data==0) locally; the ALU zero output is not used.
REQ-021 SHALL hold rsp_valid=1 with rsp_data/rsp_zero/rsp_err stable until rsp_ready=1; on that handshake, go to IDLE and increment ops_done.
REQ-022 ops_done SHALL wrap from 16'hFFFF to 0; errored responses also count.
REQ-023 SHALL ignore req_valid outside IDLE; no request queuing; minimum op period is ALU_LATENCY+3 cycles.
REQ-024 rsp_data SHALL be the full 32-bit ALU result with no saturation; overflow wraps (ALU-defined).

Reset
REQ-025 SHALL, on rst_n low at any time (including mid-WAIT/RESP), immediately enter IDLE and clear all outputs except req_ready; the in-flight op is dropped with no response.
REQ-026 Reset values SHALL be: req_ready=1 after rst_n deasserts, and rsp_valid, rsp_data, rsp_zero, rsp_err, alu_* buses, alu_enable, and ops_done all 0.

Structure
REQ-027 Package alu_pkg SHALL hold opcode constants (4-bit), data width 32, and the FSM state type; it is shared with the ALU.
REQ-028 SHALL be a single flat module; no sub-module is warranted, and the latency counter and FSM stay inline.

Verification
REQ-029 ADD a=5, b=7, rsp_ready=1 -> alu_enable is one pulse; rsp_valid is at cycle ISSUE+ALU_LATENCY+1 with rsp_data=12, zero=0, err=0; ops_done=1.
REQ-030 SUB a=3, b=3 -> rsp_data=0, rsp_zero=1; CLR (9) a=0xFFFFFFFF -> rsp_data=0, zero=1.
REQ-031 MOD a=10, b=0 and op=4'hF -> err=1, data=0; alu_enable never asserted; next RESP follows accept by one cycle.
REQ-032 MUL a=6, b=7 with rsp_ready low 5 cycles -> rsp_data=42 is held stable; req_ready=0 throughout; one ops_done increment.
REQ-033 rst_n pulsed low during WAIT of ADD 1+1 -> no rsp_valid; outputs zero; next op DECA a=0 returns 0xFFFFFFFF.
REQ-034 Preload ops_done=0xFFFF via 65535 ops (or force) -> next response yields ops_done=0.
